ysyx_22041752_meu_vl: RTL and testbench
=======================================

Name: ysyx_22041752_meu_vl

Overview:
- Parametrised memory-access stage of the in-order pipeline, sitting between EX and WB with the same valid/allowin handshake as the other stages.
- Unlike the fixed single-cycle stage, it tolerates variable-latency data-memory responses and holds a one-entry response buffer.
- It aligns load data by byte offset, with generic XLEN-based sign/zero extension.
- It supports a pipeline flush, dropping stale responses that are still in flight.

Parameters:
- XLEN, 64, register/data width; must be 32 or 64.
- PC_WD, 64, program-counter width.
- RF_ADDR_WD, 5, register-file address width.
- DROP_WD, 2, width of the stale-response drop counter (maximum 2^DROP_WD-1 dropped responses).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ws_allowin  in  1  WB can accept.
- ms_allowin  out  1  this stage can accept from EX.
- es_to_ms_valid  in  1  EX presents an instruction.
- es_pc  in  PC_WD  instruction PC.
- es_rd  in  RF_ADDR_WD  destination register.
- es_rf_we  in  1  writes the register file.
- es_mem_re  in  1  load; the request was issued by EX in the same cycle as the EX→MS handshake.
- es_mem_bytes  in  2  load size: 0=B, 1=H, 2=W, 3=D.
- es_res_sext  in  1  sign-extend the load result; when 0, zero-extend.
- es_alu_result  in  XLEN  ALU result / load address.
- data_rvalid  in  1  data-memory response strobe, exactly one per issued load.
- data_rdata  in  XLEN  response data, naturally aligned to an XLEN-wide word.
- ms_flush  in  1  kill the instruction held in MS.
- ms_to_ws_valid  out  1  result valid to WB.
- ms_to_ws_bus  out  1+RF_ADDR_WD+XLEN+PC_WD  {rf_we, rd, final_result, pc}.
- ms_fwd_valid  out  1  forwarding value usable.
- ms_fwd_busy  out  1  MS holds a load to rd whose data has not arrived; ID must stall.
- ms_fwd_bus  out  XLEN+RF_ADDR_WD  {final_result, rd}.

Behaviour:
- Reset (async, reset=0): ms_valid=0, got_resp=0, drop_cnt=0. Consequently ms_to_ws_valid=0, ms_allowin=1, ms_fwd_valid=0, ms_fwd_busy=0. Payload registers are not reset.
- Handshake: ms_allowin = !ms_valid || (ms_ready_go && ws_allowin). ms_to_ws_valid = ms_valid && ms_ready_go.
- ms_ready_go = !mem_re || got_resp || (data_rvalid && drop_cnt==0).
- Accept: on es_to_ms_valid && ms_allowin, latch all es_* fields and set ms_valid=1. When ms_allowin=1 and es_to_ms_valid=0, set ms_valid=0.
- Response steering: a response with drop_cnt!=0 decrements drop_cnt and is discarded. Otherwise, if ms_valid && mem_re && !got_resp:
  - it is used combinationally this cycle;
  - if the instruction does not leave this cycle, it is captured into rdata_buf and got_resp=1.
- got_resp clears when the instruction leaves MS, or on flush.
- A response arriving with no pending load and drop_cnt==0 is a protocol error: ignore it and assert the simulation-only check.
- Minimum load latency: a response in the cycle after the handshake gives a 0-cycle MS stall. Each later cycle adds one stall cycle.
- Flush (ms_flush=1): ms_valid<=0 and got_resp<=0. If the killed instruction was a load whose response has not arrived (including one not arriving this cycle), drop_cnt increments. On simultaneous increment and decrement, drop_cnt is unchanged. ms_flush has priority over accept: no accept occurs in a flush cycle.
- drop_cnt saturates at its maximum: no wrap; assert.
- Load extraction: off = alu_result[log2(XLEN/8)-1:0]; shifted = rdata >> (8*off), with rdata = got_resp ? rdata_buf : data_rdata.
  - Size B/H/W/D takes 8/16/32/64 LSBs, then sign-extends (es_res_sext=1) or zero-extends to XLEN.
  - With XLEN=32, size D returns the full word.
  - Misaligned accesses that cross the word return the shifted bits only; no trap is raised.
- final_result = mem_re ? extracted : alu_result.
- Forwarding:
  - ms_fwd_valid = ms_valid && rf_we && ms_ready_go.
  - ms_fwd_busy = ms_valid && rf_we && mem_re && !ms_ready_go.
  - ms_fwd_bus uses final_result and rd.

Test Plan:
- Reset low mid-stall with a load pending → all valid/busy outputs 0 immediately (async); after release, ms_allowin=1 and drop_cnt=0.
- Non-load ADD, rd=5, alu_result=0x1234, ws_allowin=1 → ms_to_ws_valid the next cycle with final_result=0x1234, ms_fwd_valid=1.
- LB, addr low bits=3, data_rdata=0x00000000_80FF0000, response the next cycle → result 0xFFFFFFFF_FFFFFF80. Same with LBU → 0x80. LHU at offset 2 → 0x80FF.
- LW with response 3 cycles late while ws_allowin toggles → ms_fwd_busy=1 for 3 cycles, then the result is captured in the buffer and delivered when ws_allowin=1; exactly one ms_to_ws_valid handshake.
- Load flushed before its response, new load accepted the next cycle; old response 0xAAAA then new response 0x5555 → 0xAAAA dropped (drop_cnt 1→0), WB receives 0x5555.
- Flush in the same cycle as es_to_ms_valid → not accepted; ms_valid=0 the next cycle.

Source files
------------

// File: rtl/ysyx_22041752_meu_vl.sv
// Memory-access stage (MS) of the in-order pipeline, between EX and WB.
// It accepts instructions from EX with the valid/allowin handshake and
// waits for variable-latency data-memory load responses. A one-entry
// buffer holds a response that arrives while WB is not accepting. The
// stage aligns load data by byte offset and sign- or zero-extends it.
// On a flush it counts the load responses still in flight so that they
// can be dropped when they arrive.
//
// Ports:
//   clk, reset         rising-edge clock; asynchronous active-low reset
//   ws_allowin         WB can accept a result this cycle
//   ms_allowin         MS can accept from EX this cycle
//   es_to_ms_valid     EX presents an instruction, with fields es_*
//   es_pc / es_rd      instruction PC and destination register
//   es_rf_we           instruction writes the register file
//   es_mem_re          instruction is a load; its request went out with the handshake
//   es_mem_bytes       load size: 0=B, 1=H, 2=W, 3=D
//   es_res_sext        sign-extend the load result (0: zero-extend)
//   es_alu_result      ALU result, or the load address
//   data_rvalid/rdata  data-memory response strobe and XLEN-aligned word
//   ms_flush           kill the instruction held in MS
//   ms_to_ws_valid/bus result to WB: {rf_we, rd, final_result, pc}
//   ms_fwd_valid       forwarding value usable
//   ms_fwd_busy        MS holds a load to rd with data outstanding (ID stalls)
//   ms_fwd_bus         {final_result, rd}
module ysyx_22041752_meu_vl #(
    parameter int XLEN       = 64,
    parameter int PC_WD      = 64,
    parameter int RF_ADDR_WD = 5,
    parameter int DROP_WD    = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                ws_allowin,
    output logic                                ms_allowin,
    input  logic                                es_to_ms_valid,
    input  logic [PC_WD-1:0]                    es_pc,
    input  logic [RF_ADDR_WD-1:0]               es_rd,
    input  logic                                es_rf_we,
    input  logic                                es_mem_re,
    input  logic [1:0]                          es_mem_bytes,
    input  logic                                es_res_sext,
    input  logic [XLEN-1:0]                     es_alu_result,
    input  logic                                data_rvalid,
    input  logic [XLEN-1:0]                     data_rdata,
    input  logic                                ms_flush,
    output logic                                ms_to_ws_valid,
    output logic [1+RF_ADDR_WD+XLEN+PC_WD-1:0]  ms_to_ws_bus,
    output logic                                ms_fwd_valid,
    output logic                                ms_fwd_busy,
    output logic [XLEN+RF_ADDR_WD-1:0]          ms_fwd_bus
);

    localparam int                  OFF_WD   = $clog2(XLEN / 8);
    localparam logic [DROP_WD-1:0]  DROP_MAX = '1;

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("ysyx_22041752_meu_vl: XLEN must be 32 or 64");
    end

    // Control state
    logic               ms_valid;
    logic               got_resp;
    logic [DROP_WD-1:0] drop_cnt;

    // Payload latched from EX
    logic [PC_WD-1:0]      pc;
    logic [RF_ADDR_WD-1:0] rd;
    logic                  rf_we;
    logic                  mem_re;
    logic [1:0]            mem_bytes;
    logic                  res_sext;
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       rdata_buf;

    logic resp_live;   // response belongs to the current load
    logic resp_drop;   // response belongs to a flushed load
    logic load_wait;   // valid load whose data has not been seen yet
    logic resp_use;
    logic ms_ready_go;
    logic ms_leave;
    logic accept;
    logic drop_inc;

    assign resp_drop      = data_rvalid && (drop_cnt != '0);
    assign resp_live      = data_rvalid && (drop_cnt == '0);
    assign load_wait      = ms_valid && mem_re && !got_resp;
    assign resp_use       = resp_live && load_wait;
    assign ms_ready_go    = !mem_re || got_resp || resp_live;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign ms_leave       = ms_to_ws_valid && ws_allowin;
    assign accept         = es_to_ms_valid && ms_allowin && !ms_flush;
    // A killed load whose data is not arriving this cycle still owes a response.
    assign drop_inc       = ms_flush && load_wait && !resp_live;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ms_valid <= 1'b0;
            got_resp <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (ms_flush) begin
                ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end

            if (ms_flush || ms_leave) begin
                got_resp <= 1'b0;
            end else if (resp_use) begin
                got_resp <= 1'b1;
            end

            // Simultaneous increment and decrement cancel out.
            unique case ({drop_inc, resp_drop})
                2'b10:   if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 1'b1;
                2'b01:   drop_cnt <= drop_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: payload and buffer registers have no reset; they are only read
    // while ms_valid/got_resp qualify them.
    always_ff @(posedge clk) begin
        if (accept) begin
            pc         <= es_pc;
            rd         <= es_rd;
            rf_we      <= es_rf_we;
            mem_re     <= es_mem_re;
            mem_bytes  <= es_mem_bytes;
            res_sext   <= es_res_sext;
            alu_result <= es_alu_result;
        end
        if (resp_use && !ms_leave) begin
            rdata_buf <= data_rdata;
        end
    end

    // Load extraction: shift the addressed byte to bit 0, keep `width` bits,
    // then fill the upper bits with the sign bit or zeros.
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] sign_probe;
    logic [XLEN-1:0] extracted;
    logic [7:0]      width;
    logic [XLEN-1:0] final_result;

    // NOTE: every always_comb output gets a value on every path, so no latch
    // is inferred.
    always_comb begin
        rdata   = got_resp ? rdata_buf : data_rdata;
        shifted = rdata >> {alu_result[OFF_WD-1:0], 3'b000};
        unique case (mem_bytes)
            2'd0:    width = 8'd8;
            2'd1:    width = 8'd16;
            2'd2:    width = 8'd32;
            default: width = 8'd64;
        endcase
        // With XLEN=32 a doubleword load returns the whole word.
        if (width > 8'(XLEN)) width = 8'(XLEN);
        mask       = {XLEN{1'b1}} >> (8'(XLEN) - width);
        sign_probe = shifted >> (width - 8'd1);
        extracted  = shifted & mask;
        if (res_sext && sign_probe[0]) extracted = extracted | ~mask;
    end

    assign final_result = mem_re ? extracted : alu_result;

    assign ms_to_ws_bus = {rf_we, rd, final_result, pc};
    assign ms_fwd_valid = ms_valid && rf_we && ms_ready_go;
    assign ms_fwd_busy  = ms_valid && rf_we && mem_re && !ms_ready_go;
    assign ms_fwd_bus   = {final_result, rd};

    // Simulation-only protocol checks.
    always @(posedge clk) begin
        if (reset) begin
            assert (!(resp_live && !load_wait))
                else $error("meu_vl: data response with no pending load");
            assert (!(drop_inc && !resp_drop && drop_cnt == DROP_MAX))
                else $error("meu_vl: drop counter saturated");
        end
    end

endmodule

// File: tb/tb_ysyx_22041752_meu_vl.sv
// Directed testbench for ysyx_22041752_meu_vl (XLEN=64). Inputs are driven
// one time unit after the rising edge and outputs are sampled mid-cycle.
// Expected values are hand-computed constants.
module tb_ysyx_22041752_meu_vl;

    localparam int XLEN = 64;
    localparam int PC_WD = 64;
    localparam int RF_ADDR_WD = 5;
    localparam int DROP_WD = 2;

    logic                               clk;
    logic                               reset;
    logic                               ws_allowin;
    logic                               ms_allowin;
    logic                               es_to_ms_valid;
    logic [PC_WD-1:0]                   es_pc;
    logic [RF_ADDR_WD-1:0]              es_rd;
    logic                               es_rf_we;
    logic                               es_mem_re;
    logic [1:0]                         es_mem_bytes;
    logic                               es_res_sext;
    logic [XLEN-1:0]                    es_alu_result;
    logic                               data_rvalid;
    logic [XLEN-1:0]                    data_rdata;
    logic                               ms_flush;
    logic                               ms_to_ws_valid;
    logic [1+RF_ADDR_WD+XLEN+PC_WD-1:0] ms_to_ws_bus;
    logic                               ms_fwd_valid;
    logic                               ms_fwd_busy;
    logic [XLEN+RF_ADDR_WD-1:0]         ms_fwd_bus;

    ysyx_22041752_meu_vl #(
        .XLEN(XLEN), .PC_WD(PC_WD), .RF_ADDR_WD(RF_ADDR_WD), .DROP_WD(DROP_WD)
    ) dut (
        .clk(clk), .reset(reset), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
        .es_to_ms_valid(es_to_ms_valid), .es_pc(es_pc), .es_rd(es_rd),
        .es_rf_we(es_rf_we), .es_mem_re(es_mem_re), .es_mem_bytes(es_mem_bytes),
        .es_res_sext(es_res_sext), .es_alu_result(es_alu_result),
        .data_rvalid(data_rvalid), .data_rdata(data_rdata), .ms_flush(ms_flush),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
        .ms_fwd_valid(ms_fwd_valid), .ms_fwd_busy(ms_fwd_busy), .ms_fwd_bus(ms_fwd_bus)
    );

    wire                  bus_we    = ms_to_ws_bus[133];
    wire [4:0]            bus_rd    = ms_to_ws_bus[132:128];
    wire [63:0]           bus_final = ms_to_ws_bus[127:64];
    wire [63:0]           bus_pc    = ms_to_ws_bus[63:0];
    wire [63:0]           fwd_final = ms_fwd_bus[68:5];
    wire [4:0]            fwd_rd    = ms_fwd_bus[4:0];

    int checks = 0;
    int failures = 0;
    int hs_cnt = 0;
    int hs0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Count WB handshakes with inputs settled, then advance one clock.
    task automatic tick();
        #1;
        if (ms_to_ws_valid && ws_allowin) hs_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        es_to_ms_valid = 1'b0;
        data_rvalid    = 1'b0;
        ms_flush       = 1'b0;
        ws_allowin     = 1'b1;
    endtask

    task automatic present(input logic [63:0] pc, input logic [4:0] rd, input logic we,
                           input logic re, input logic [1:0] bytes, input logic sext,
                           input logic [63:0] alu);
        es_to_ms_valid = 1'b1;
        es_pc          = pc;
        es_rd          = rd;
        es_rf_we       = we;
        es_mem_re      = re;
        es_mem_bytes   = bytes;
        es_res_sext    = sext;
        es_alu_result  = alu;
    endtask

    // Load with its response in the cycle after the handshake (no stall).
    task automatic do_load(input string tag, input logic [63:0] addr, input logic [1:0] bytes,
                           input logic sext, input logic [63:0] rdata, input logic [63:0] exp);
        idle();
        present(64'h8000_0100, 5'd7, 1'b1, 1'b1, bytes, sext, addr);
        #1 check({tag, "_allowin"}, ms_allowin, 1);
        tick();
        idle();
        #1 check({tag, "_busy"}, ms_fwd_busy, 1);
        check({tag, "_wait"}, ms_to_ws_valid, 0);
        data_rvalid = 1'b1;
        data_rdata  = rdata;
        #1 check({tag, "_valid"}, ms_to_ws_valid, 1);
        check({tag, "_result"}, bus_final, exp);
        check({tag, "_fwd"}, fwd_final, exp);
        check({tag, "_nobusy"}, ms_fwd_busy, 0);
        tick();
        idle();
    endtask

    initial begin
        reset = 1'b0;
        idle();
        present(64'h0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0);
        es_to_ms_valid = 1'b0;
        data_rdata = '0;
        #2;
        check("rst_to_ws", ms_to_ws_valid, 0);
        check("rst_allowin", ms_allowin, 1);
        check("rst_fwd_valid", ms_fwd_valid, 0);
        check("rst_fwd_busy", ms_fwd_busy, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();

        // Non-load ADD
        idle();
        present(64'h8000_0000, 5'd5, 1'b1, 1'b0, 2'd0, 1'b0, 64'h1234);
        #1 check("add_allowin", ms_allowin, 1);
        tick();
        idle();
        #1 check("add_valid", ms_to_ws_valid, 1);
        check("add_result", bus_final, 64'h1234);
        check("add_rd", bus_rd, 5);
        check("add_we", bus_we, 1);
        check("add_pc", bus_pc, 64'h8000_0000);
        check("add_fwd_valid", ms_fwd_valid, 1);
        check("add_fwd_val", fwd_final, 64'h1234);
        check("add_fwd_rd", fwd_rd, 5);
        tick();
        #1 check("add_gone", ms_to_ws_valid, 0);

        // Aligned extraction
        do_load("lb", 64'h1003, 2'd0, 1'b1, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FF80);
        do_load("lbu", 64'h1003, 2'd0, 1'b0, 64'h0000_0000_80FF_0000, 64'h80);
        do_load("lhu", 64'h1002, 2'd1, 1'b0, 64'h0000_0000_80FF_0000, 64'h80FF);
        do_load("ld", 64'h2000, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
        // Misaligned halfword crossing the word: only the shifted-in byte remains
        do_load("lh_cross", 64'h1007, 2'd1, 1'b1, 64'hAB00_0000_0000_0000, 64'hAB);

        // LW answered 3 cycles late while WB toggles
        hs0 = hs_cnt;
        idle();
        present(64'h8000_0200, 5'd9, 1'b1, 1'b1, 2'd2, 1'b1, 64'h2004);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle();
            ws_allowin = (i == 1);
            #1 check("lw_busy", ms_fwd_busy, 1);
            check("lw_wait", ms_to_ws_valid, 0);
            tick();
        end
        idle();
        ws_allowin  = 1'b0;
        data_rvalid = 1'b1;
        data_rdata  = 64'hDEAD_BEEF_0000_0000;
        #1 check("lw_resp_valid", ms_to_ws_valid, 1);
        check("lw_resp_result", bus_final, 64'hFFFF_FFFF_DEAD_BEEF);
        check("lw_resp_fwd", ms_fwd_valid, 1);
        check("lw_resp_busy", ms_fwd_busy, 0);
        tick();
        idle();
        ws_allowin = 1'b0;
        data_rdata = 64'h0;
        #1 check("lw_buf_valid", ms_to_ws_valid, 1);
        check("lw_buf_result", bus_final, 64'hFFFF_FFFF_DEAD_BEEF);
        check("lw_buf_allowin", ms_allowin, 0);
        tick();
        idle();
        #1 check("lw_out_result", bus_final, 64'hFFFF_FFFF_DEAD_BEEF);
        tick();
        #1 check("lw_gone", ms_to_ws_valid, 0);
        check("lw_handshakes", hs_cnt - hs0, 1);

        // Flush a pending load; its stale response must be dropped
        hs0 = hs_cnt;
        idle();
        present(64'h8000_0300, 5'd10, 1'b1, 1'b1, 2'd3, 1'b0, 64'h3000);
        tick();
        idle();
        ms_flush = 1'b1;
        #1 check("fl_busy", ms_fwd_busy, 1);
        tick();
        idle();
        #1 check("fl_killed", ms_to_ws_valid, 0);
        check("fl_allowin", ms_allowin, 1);
        present(64'h8000_0308, 5'd12, 1'b1, 1'b1, 2'd3, 1'b0, 64'h4000);
        tick();
        idle();
        data_rvalid = 1'b1;
        data_rdata  = 64'hAAAA;
        #1 check("fl_stale_valid", ms_to_ws_valid, 0);
        check("fl_stale_busy", ms_fwd_busy, 1);
        tick();
        idle();
        data_rvalid = 1'b1;
        data_rdata  = 64'h5555;
        #1 check("fl_new_valid", ms_to_ws_valid, 1);
        check("fl_new_result", bus_final, 64'h5555);
        tick();
        idle();
        #1 check("fl_handshakes", hs_cnt - hs0, 1);

        // Flush in the same cycle as a new EX instruction: not accepted
        present(64'h8000_0400, 5'd13, 1'b1, 1'b0, 2'd0, 1'b0, 64'h99);
        tick();
        present(64'h8000_0404, 5'd14, 1'b1, 1'b0, 2'd0, 1'b0, 64'h42);
        ms_flush = 1'b1;
        #1 check("fa_allowin", ms_allowin, 1);
        tick();
        idle();
        #1 check("fa_not_accepted", ms_to_ws_valid, 0);
        check("fa_fwd", ms_fwd_valid, 0);

        // Flush of a pending load while an older stale response is dropped
        present(64'h8000_0500, 5'd15, 1'b1, 1'b1, 2'd3, 1'b0, 64'h5000);
        tick();
        idle();
        ms_flush = 1'b1;
        tick();
        idle();
        present(64'h8000_0508, 5'd16, 1'b1, 1'b1, 2'd3, 1'b0, 64'h5008);
        tick();
        idle();
        ms_flush    = 1'b1;
        data_rvalid = 1'b1;
        data_rdata  = 64'h1111;
        #1 check("sim_busy", ms_fwd_busy, 1);
        tick();
        idle();
        present(64'h8000_0510, 5'd17, 1'b1, 1'b1, 2'd3, 1'b0, 64'h6000);
        tick();
        idle();
        data_rvalid = 1'b1;
        data_rdata  = 64'h2222;
        #1 check("sim_stale_valid", ms_to_ws_valid, 0);
        tick();
        idle();
        data_rvalid = 1'b1;
        data_rdata  = 64'h3333;
        #1 check("sim_new_valid", ms_to_ws_valid, 1);
        check("sim_new_result", bus_final, 64'h3333);
        tick();
        idle();

        // Asynchronous reset mid-stall, with a stale response outstanding
        present(64'h8000_0600, 5'd18, 1'b1, 1'b1, 2'd3, 1'b0, 64'h7000);
        tick();
        idle();
        ms_flush = 1'b1;
        tick();
        idle();
        present(64'h8000_0608, 5'd19, 1'b1, 1'b1, 2'd3, 1'b0, 64'h7008);
        tick();
        idle();
        #1 check("ar_busy_before", ms_fwd_busy, 1);
        reset = 1'b0;
        #1 check("ar_to_ws", ms_to_ws_valid, 0);
        check("ar_busy", ms_fwd_busy, 0);
        check("ar_fwd_valid", ms_fwd_valid, 0);
        check("ar_allowin", ms_allowin, 1);
        tick();
        reset = 1'b1;
        tick();
        do_load("post_reset", 64'h1000, 2'd2, 1'b0, 64'h0000_0000_CAFE_F00D, 64'hCAFE_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
